// File: rtl/fp_mantissa_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_mantissa_divider_pkg
// Brief    : FP divide widths and unsigned-division interface structs.
// Revision : 1.0
// ============================================================================
package fp_mantissa_divider_pkg;

  localparam int FRAC_WIDTH   = 52;
  localparam int FP_DIV_WIDTH = FRAC_WIDTH + 3;

  typedef logic [FRAC_WIDTH-1:0]   frac_t;
  typedef logic [FP_DIV_WIDTH-1:0] div_word_t;

  typedef struct packed {
    logic      start;
    div_word_t dividend;
    div_word_t divisor;
  } div_in_t;

  typedef struct packed {
    div_word_t quotient;
    div_word_t remainder;
    logic      done;
  } div_out_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } div_state_t;

endpackage
`default_nettype wire

// File: rtl/fp_mantissa_divider.sv
`default_nettype none
// ============================================================================
// Module   : fp_mantissa_divider
// Brief    : Iterative radix-2 restoring mantissa divider, one quotient bit/cycle.
// Revision : 1.0
// ============================================================================
module fp_mantissa_divider
  import fp_mantissa_divider_pkg::*;
#(
  parameter int  DATA_WIDTH = FP_DIV_WIDTH,
  parameter type IN_T       = div_in_t,
  parameter type OUT_T      = div_out_t
) (
  input  logic clk,
  input  logic rst,
  input  IN_T  div_input,
  output OUT_T div_output
);

  localparam int                c_CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_WIDTH - 1);

  div_state_t              r_state;
  div_state_t              w_state_next;
  logic [DATA_WIDTH:0]     r_pr;
  logic [DATA_WIDTH-1:0]   r_div;
  logic [DATA_WIDTH-1:0]   r_quo;
  logic [c_CNT_W-1:0]      r_cnt;
  logic                    r_done;
  logic                    w_last;
  logic [DATA_WIDTH+1:0]   w_diff;
  logic                    w_bit;
  logic [DATA_WIDTH:0]     w_pr_sub;

  // Conditional-subtract step; the sign of the widened difference is the quotient bit.
  always_comb begin
    w_diff   = {1'b0, r_pr} - {2'b00, r_div};
    w_bit    = ~w_diff[DATA_WIDTH+1];
    w_pr_sub = w_bit ? w_diff[DATA_WIDTH:0] : r_pr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A new start pre-empts the final iteration, so the abandoned result never signals done.
  always_comb begin
    w_state_next = r_state;
    w_last       = 1'b0;
    if (div_input.start) begin
      w_state_next = ST_BUSY;
    end else if (r_state == ST_BUSY && r_cnt == '0) begin
      w_state_next = ST_IDLE;
      w_last       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pr   <= '0;
      r_div  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (div_input.start) begin
        r_pr  <= {1'b0, div_input.dividend};
        r_div <= div_input.divisor;
        r_cnt <= c_CNT_LAST;
      end else if (r_state == ST_BUSY) begin
        r_quo <= {r_quo[DATA_WIDTH-2:0], w_bit};
        if (w_last) begin
          r_pr <= w_pr_sub;
        end else begin
          r_pr  <= {w_pr_sub[DATA_WIDTH-1:0], 1'b0};
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  // After the last bit the partial remainder is below the divisor, so it fits W bits.
  always_comb begin
    div_output           = '0;
    div_output.quotient  = r_quo;
    div_output.remainder = r_pr[DATA_WIDTH-1:0];
    div_output.done      = r_done;
  end

endmodule
`default_nettype wire
